flag_pc_unit: RTL

- Control stage directly downstream of the ALU.
- Captures the ALU status outputs (zero, greater, shift/carry) into a flag register.
- Feeds the stored flags back to the ALU's ZERO_IN / GREATER_IN / SC_IN inputs.
- Uses the same flags to resolve conditional branches and owns the program counter plus the program start/halt sequencing.

---
 rtl/flag_pc_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/flag_pc_unit.sv
// Flag register, branch resolution and program counter sequencing for the
// control stage that sits directly behind the ALU.
module flag_pc_unit #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned START_ADDR = 0
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Halt,
  input  logic            FlagWrEn,
  input  logic            ZeroIn,
  input  logic            GreaterIn,
  input  logic            ScIn,
  input  logic [1:0]      BranchType,
  input  logic            TargetSel,
  input  logic [7:0]      Offset,
  input  logic [PC_W-1:0] AbsTarget,
  output logic [PC_W-1:0] PC,
  output logic            ZeroFlag,
  output logic            GreaterFlag,
  output logic            ScFlag,
  output logic            BranchTaken,
  output logic            Running,
  output logic            Done
);

  localparam logic [1:0] BR_NONE  = 2'b00;
  localparam logic [1:0] BR_ZERO  = 2'b01;
  localparam logic [1:0] BR_GREAT = 2'b10;
  localparam logic [1:0] BR_ALWAYS = 2'b11;

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [PC_W-1:0] pc_next;
  logic            zero_next, greater_next, sc_next;
  logic            cond;
  logic [PC_W-1:0] offset_ext;
  logic [PC_W-1:0] target;

  // Branch condition is evaluated on the stored flags, never the live ALU outputs.
  always_comb begin
    cond = 1'b0;
    case (BranchType)
      BR_NONE:   cond = 1'b0;
      BR_ZERO:   cond = ZeroFlag;
      BR_GREAT:  cond = GreaterFlag;
      BR_ALWAYS: cond = 1'b1;
      default:   cond = 1'b0;
    endcase
  end

  assign offset_ext  = PC_W'($signed(Offset));
  assign target      = TargetSel ? AbsTarget : PC_W'(PC + offset_ext);
  assign BranchTaken = (state == ST_RUN) && cond && !Halt;

  // Next-state, next-PC and next-flag selection.
  always_comb begin
    state_next   = state;
    pc_next      = PC;
    zero_next    = ZeroFlag;
    greater_next = GreaterFlag;
    sc_next      = ScFlag;
    case (state)
      ST_IDLE, ST_HALTED: begin
        if (Start) begin
          state_next   = ST_RUN;
          pc_next      = START_PC;
          zero_next    = 1'b0;
          greater_next = 1'b0;
          sc_next      = 1'b0;
        end
      end
      ST_RUN: begin
        if (Halt) begin
          state_next = ST_HALTED;
        end else begin
          pc_next = BranchTaken ? target : PC_W'(PC + PC_W'(1));
          if (FlagWrEn) begin
            zero_next    = ZeroIn;
            greater_next = GreaterIn;
            sc_next      = ScIn;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= ST_IDLE;
      PC          <= START_PC;
      ZeroFlag    <= 1'b0;
      GreaterFlag <= 1'b0;
      ScFlag      <= 1'b0;
      Running     <= 1'b0;
      Done        <= 1'b0;
    end else begin
      state       <= state_next;
      PC          <= pc_next;
      ZeroFlag    <= zero_next;
      GreaterFlag <= greater_next;
      ScFlag      <= sc_next;
      Running     <= (state_next == ST_RUN);
      Done        <= (state_next == ST_HALTED);
    end
  end

endmodule
